tdc_interval: RTL and testbench

Downstream consumer of the two-channel thermometer-to-binary fine-code decoder in the real-time-feedback TDC path. It receives the 6-bit fine codes for a start channel and a stop channel, plus per-channel hit flags presented in the same cycle the raw delay-line words enter the decoder. It delays the flags to line up with the decoder latency and combines them with a free-running coarse counter. For each armed measurement it reports a start-to-stop interval in fine-bin units.

---
 rtl/tdc_interval_if.sv | 32 +++
 rtl/tdc_interval.sv | 148 ++++++++++++++
 tb/tb_tdc_interval.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tdc_interval_if.sv
// tdc_interval_if: signal bundle between the TDC interval block and its
// surroundings.
//   master : drives arm, start_hit, stop_hit, fine_start, fine_stop;
//            receives interval, valid, timeout, neg_err, busy.
//   slave  : the interval block itself (mirror of master).
// COARSE_W must match the COARSE_W of the attached tdc_interval.
interface tdc_interval_if #(
  parameter int COARSE_W = 16
);
  localparam int RES_W = COARSE_W + 6;

  logic             arm;
  logic             start_hit;
  logic             stop_hit;
  logic [5:0]       fine_start;
  logic [5:0]       fine_stop;
  logic [RES_W-1:0] interval;
  logic             valid;
  logic             timeout;
  logic             neg_err;
  logic             busy;

  modport master (
    output arm, start_hit, stop_hit, fine_start, fine_stop,
    input  interval, valid, timeout, neg_err, busy
  );

  modport slave (
    input  arm, start_hit, stop_hit, fine_start, fine_stop,
    output interval, valid, timeout, neg_err, busy
  );
endinterface

// File: rtl/tdc_interval.sv
// tdc_interval: start-to-stop interval measurement in fine-bin units.
// Hit flags are delayed to line up with the fine-code decoder output and
// combined with a free-running coarse counter; one result per arm.
//   clk, rst       : clock (rising edge), synchronous active-high reset
//   bus.arm        : request one measurement (accepted only in IDLE)
//   bus.start_hit  : start hit, aligned with the raw delay-line word
//   bus.stop_hit   : stop hit, same alignment
//   bus.fine_start : decoded fine code, start channel
//   bus.fine_stop  : decoded fine code, stop channel
//   bus.interval   : measured interval (fine bins), held until next valid
//   bus.valid      : one-cycle strobe qualifying interval/timeout/neg_err
//   bus.timeout    : no stop within TIMEOUT cycles of start
//   bus.neg_err    : stop earlier than start within the same coarse cycle
//   bus.busy       : high outside IDLE
module tdc_interval #(
  parameter int COARSE_W  = 16,
  parameter int FINE_BINS = 40,
  parameter int DEC_LAT   = 7,
  parameter int TIMEOUT   = 1000
) (
  input logic        clk,
  input logic        rst,
  tdc_interval_if.slave bus
);
  localparam int RES_W = COARSE_W + 6;
  localparam logic [31:0] FB = 32'(FINE_BINS);

  typedef enum logic [2:0] {IDLE, ARMED, WAIT_STOP, CALC, DONE} state_t;

  state_t state, state_d;

  logic [DEC_LAT-1:0]  start_sr, stop_sr;
  logic                d_start, d_stop;
  logic [COARSE_W-1:0] coarse, c_s, c_p, span, coarse_diff;
  logic [5:0]          f_s, f_p;
  logic [RES_W-1:0]    scaled;
  logic [RES_W:0]      diff_full;
  logic                cap_start, cap_stop, expire;
  logic [RES_W-1:0]    interval_q;
  logic                valid_q, timeout_q, neg_err_q;

  function automatic logic [5:0] clamp(input logic [5:0] f);
    clamp = (f > 6'(FINE_BINS)) ? 6'(FINE_BINS) : f;
  endfunction

  assign d_start = start_sr[DEC_LAT-1];
  assign d_stop  = stop_sr[DEC_LAT-1];

  always_comb begin
    state_d   = state;
    cap_start = 1'b0;
    cap_stop  = 1'b0;
    expire    = 1'b0;
    case (state)
      IDLE: if (bus.arm) state_d = ARMED;
      ARMED: begin
        // A lone stop is ignored; a start opens the window.
        if (d_start) begin
          cap_start = 1'b1;
          if (d_stop) begin
            cap_stop = 1'b1;
            state_d  = CALC;
          end else begin
            state_d = WAIT_STOP;
          end
        end
      end
      WAIT_STOP: begin
        // Stop wins over timeout when both land in the same cycle.
        if (d_stop) begin
          cap_stop = 1'b1;
          state_d  = CALC;
        end else if (span == COARSE_W'(TIMEOUT)) begin
          expire  = 1'b1;
          state_d = DONE;
        end
      end
      CALC:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // (c_p - c_s) * FINE_BINS as a constant shift-add, then fine correction.
  // Later fine code = earlier hit, so t = coarse*FINE_BINS - fine.
  always_comb begin
    coarse_diff = c_p - c_s;
    scaled      = '0;
    for (int unsigned i = 0; i < RES_W; i++) begin
      if (FB[i]) scaled = scaled + (RES_W'(coarse_diff) << i);
    end
    diff_full = {1'b0, scaled} + (RES_W+1)'(f_s) - (RES_W+1)'(f_p);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      start_sr   <= '0;
      stop_sr    <= '0;
      coarse     <= '0;
      span       <= '0;
      c_s        <= '0;
      c_p        <= '0;
      f_s        <= '0;
      f_p        <= '0;
      interval_q <= '0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
      neg_err_q  <= 1'b0;
    end else begin
      state    <= state_d;
      start_sr <= (start_sr << 1) | DEC_LAT'(bus.start_hit);
      stop_sr  <= (stop_sr << 1) | DEC_LAT'(bus.stop_hit);
      coarse   <= coarse + COARSE_W'(1);

      if (cap_start) begin
        c_s  <= coarse;
        f_s  <= clamp(bus.fine_start);
        span <= COARSE_W'(1);
      end else if (state == WAIT_STOP) begin
        span <= span + COARSE_W'(1);
      end

      if (cap_stop) begin
        c_p <= coarse;
        f_p <= clamp(bus.fine_stop);
      end

      valid_q <= (state_d == DONE);

      if (state == CALC) begin
        timeout_q  <= 1'b0;
        neg_err_q  <= diff_full[RES_W];
        interval_q <= diff_full[RES_W] ? '0 : diff_full[RES_W-1:0];
      end else if (expire) begin
        timeout_q  <= 1'b1;
        neg_err_q  <= 1'b0;
        interval_q <= '0;
      end
    end
  end

  assign bus.interval = interval_q;
  assign bus.valid    = valid_q;
  assign bus.timeout  = timeout_q;
  assign bus.neg_err  = neg_err_q;
  assign bus.busy     = (state != IDLE);
endmodule

// File: tb/tb_tdc_interval.sv
// tb_tdc_interval: directed bench for tdc_interval. A small pipeline stands
// in for the fine-code decoder so fine codes arrive DEC_LAT cycles after
// the raw hit, as in the real path.
module tb_tdc_interval;
  localparam int COARSE_W  = 16;
  localparam int FINE_BINS = 40;
  localparam int DEC_LAT   = 7;
  localparam int TIMEOUT   = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tdc_interval_if #(.COARSE_W(COARSE_W)) bus ();

  tdc_interval #(
    .COARSE_W (COARSE_W),
    .FINE_BINS(FINE_BINS),
    .DEC_LAT  (DEC_LAT),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  logic [5:0]  raw_fs, raw_fp;
  logic [5:0]  fs_pipe [DEC_LAT];
  logic [5:0]  fp_pipe [DEC_LAT];
  logic [15:0] tb_coarse;

  always @(posedge clk) begin
    fs_pipe[0] <= raw_fs;
    fp_pipe[0] <= raw_fp;
    for (int i = 1; i < DEC_LAT; i++) begin
      fs_pipe[i] <= fs_pipe[i-1];
      fp_pipe[i] <= fp_pipe[i-1];
    end
  end
  assign bus.fine_start = fs_pipe[DEC_LAT-1];
  assign bus.fine_stop  = fp_pipe[DEC_LAT-1];

  always @(posedge clk) begin
    if (rst) tb_coarse <= '0;
    else     tb_coarse <= tb_coarse + 16'd1;
  end

  int total = 0;
  int bad   = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm();
    bus.arm = 1'b1;
    step();
    bus.arm = 1'b0;
  endtask

  task automatic hit(input logic s, input logic p, input logic [5:0] fs, input logic [5:0] fp);
    bus.start_hit = s;
    bus.stop_hit  = p;
    raw_fs = fs;
    raw_fp = fp;
    step();
    bus.start_hit = 1'b0;
    bus.stop_hit  = 1'b0;
    raw_fs = '0;
    raw_fp = '0;
  endtask

  task automatic test_reset();
    bus.arm = 1'b0; bus.start_hit = 1'b0; bus.stop_hit = 1'b0;
    raw_fs = '0; raw_fp = '0;
    rst = 1'b1;
    repeat (10) step();
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.valid); end
    total++; if (bus.interval !== 22'd0) begin bad++; $display("FAIL reset_interval got=%0d want=0", bus.interval); end
    total++; if (bus.timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b want=0", bus.timeout); end
    total++; if (bus.neg_err !== 1'b0) begin bad++; $display("FAIL reset_neg_err got=%b want=0", bus.neg_err); end
    rst = 1'b0;
    repeat (2) step();
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b want=0", bus.busy); end
  endtask

  task automatic test_nominal();
    logic early = 1'b0;
    do_arm();                       // cycle T
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL nom_busy_rise got=%b want=1", bus.busy); end
    hit(1'b1, 1'b0, 6'd30, 6'd0);   // -> T+1
    repeat (4) step();              // T+5
    hit(1'b0, 1'b1, 6'd0, 6'd10);   // -> T+6
    for (int k = 6; k < 14; k++) begin
      if (bus.valid) early = 1'b1;
      step();
    end                             // T+14
    total++; if (early !== 1'b0) begin bad++; $display("FAIL nom_early_valid got=%b want=0", early); end
    total++; if (bus.valid !== 1'b1) begin bad++; $display("FAIL nom_valid got=%b want=1", bus.valid); end
    total++; if (bus.interval !== 22'd220) begin bad++; $display("FAIL nom_interval got=%0d want=220", bus.interval); end
    total++; if (bus.timeout !== 1'b0) begin bad++; $display("FAIL nom_timeout got=%b want=0", bus.timeout); end
    total++; if (bus.neg_err !== 1'b0) begin bad++; $display("FAIL nom_neg_err got=%b want=0", bus.neg_err); end
    step();                         // T+15
    total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL nom_valid_strobe got=%b want=0", bus.valid); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL nom_busy_fall got=%b want=0", bus.busy); end
    total++; if (bus.interval !== 22'd220) begin bad++; $display("FAIL nom_hold got=%0d want=220", bus.interval); end
  endtask

  task automatic test_timeout();
    logic early = 1'b0;
    do_arm();                       // T
    hit(1'b1, 1'b0, 6'd7, 6'd0);    // -> T+1
    for (int k = 1; k < 108; k++) begin
      if (bus.valid) early = 1'b1;
      step();
    end                             // T+108 = T+DEC_LAT+TIMEOUT+1
    total++; if (early !== 1'b0) begin bad++; $display("FAIL to_early_valid got=%b want=0", early); end
    total++; if (bus.valid !== 1'b1) begin bad++; $display("FAIL to_valid got=%b want=1", bus.valid); end
    total++; if (bus.timeout !== 1'b1) begin bad++; $display("FAIL to_flag got=%b want=1", bus.timeout); end
    total++; if (bus.interval !== 22'd0) begin bad++; $display("FAIL to_interval got=%0d want=0", bus.interval); end
    total++; if (bus.neg_err !== 1'b0) begin bad++; $display("FAIL to_neg_err got=%b want=0", bus.neg_err); end
    step();
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL to_busy_fall got=%b want=0", bus.busy); end
    total++; if (bus.timeout !== 1'b1) begin bad++; $display("FAIL to_hold got=%b want=1", bus.timeout); end
  endtask

  task automatic test_same_cycle();
    logic [5:0]  fs_v  [3] = '{6'd25, 6'd10, 6'd45};
    logic [5:0]  fp_v  [3] = '{6'd5,  6'd30, 6'd50};
    logic [21:0] exp_i [3] = '{22'd20, 22'd0, 22'd0};
    logic        exp_n [3] = '{1'b0,  1'b1,  1'b0};
    for (int c = 0; c < 3; c++) begin
      logic early = 1'b0;
      do_arm();                     // T
      hit(1'b1, 1'b1, fs_v[c], fp_v[c]);
      for (int k = 1; k < 9; k++) begin
        if (bus.valid) early = 1'b1;
        step();
      end                           // T+9
      total++; if (early !== 1'b0) begin bad++; $display("FAIL same%0d_early got=%b want=0", c, early); end
      total++; if (bus.valid !== 1'b1) begin bad++; $display("FAIL same%0d_valid got=%b want=1", c, bus.valid); end
      total++; if (bus.interval !== exp_i[c]) begin bad++; $display("FAIL same%0d_interval got=%0d want=%0d", c, bus.interval, exp_i[c]); end
      total++; if (bus.neg_err !== exp_n[c]) begin bad++; $display("FAIL same%0d_neg_err got=%b want=%b", c, bus.neg_err, exp_n[c]); end
      total++; if (bus.timeout !== 1'b0) begin bad++; $display("FAIL same%0d_timeout got=%b want=0", c, bus.timeout); end
      step();
    end
  endtask

  task automatic test_ordering();
    logic early = 1'b0;
    do_arm();                       // T
    hit(1'b0, 1'b1, 6'd0, 6'd2);    // stop at T, ignored
    step();
    hit(1'b1, 1'b0, 6'd20, 6'd0);   // start at T+2, wins
    step();
    hit(1'b1, 1'b0, 6'd35, 6'd0);   // start at T+4, ignored
    step();
    hit(1'b0, 1'b1, 6'd0, 6'd15);   // stop at T+6 -> T+7
    for (int k = 7; k < 15; k++) begin
      if (bus.valid) early = 1'b1;
      step();
    end                             // T+15
    total++; if (early !== 1'b0) begin bad++; $display("FAIL ord_early got=%b want=0", early); end
    total++; if (bus.valid !== 1'b1) begin bad++; $display("FAIL ord_valid got=%b want=1", bus.valid); end
    total++; if (bus.interval !== 22'd165) begin bad++; $display("FAIL ord_interval got=%0d want=165", bus.interval); end
    step();
  endtask

  task automatic test_reset_mid();
    logic seen = 1'b0;
    do_arm();                       // T
    hit(1'b1, 1'b0, 6'd9, 6'd0);    // -> T+1
    repeat (2) step();              // T+3
    hit(1'b0, 1'b1, 6'd0, 6'd3);    // stop at T+3
    hit(1'b1, 1'b0, 6'd11, 6'd0);   // start at T+4, -> T+5
    repeat (3) step();              // T+8, WAIT_STOP
    rst = 1'b1;
    step();
    rst = 1'b0;                     // T+9
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rm_busy got=%b want=0", bus.busy); end
    total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL rm_valid got=%b want=0", bus.valid); end
    total++; if (bus.interval !== 22'd0) begin bad++; $display("FAIL rm_interval got=%0d want=0", bus.interval); end
    total++; if (bus.timeout !== 1'b0) begin bad++; $display("FAIL rm_timeout got=%b want=0", bus.timeout); end
    total++; if (bus.neg_err !== 1'b0) begin bad++; $display("FAIL rm_neg_err got=%b want=0", bus.neg_err); end
    do_arm();                       // re-arm; in-flight hits must be gone
    for (int k = 0; k < 120; k++) begin
      if (bus.valid) seen = 1'b1;
      step();
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL rm_stale_valid got=%b want=0", seen); end
    hit(1'b1, 1'b1, 6'd12, 6'd4);
    repeat (8) step();
    total++; if (bus.valid !== 1'b1) begin bad++; $display("FAIL rm_after_valid got=%b want=1", bus.valid); end
    total++; if (bus.interval !== 22'd8) begin bad++; $display("FAIL rm_after_interval got=%0d want=8", bus.interval); end
    step();
  endtask

  task automatic test_back_to_back();
    logic early = 1'b0;
    do_arm();                       // T
    hit(1'b1, 1'b1, 6'd20, 6'd10);  // -> T+1
    step();                         // T+2
    hit(1'b1, 1'b0, 6'd7, 6'd0);    // d_start lands in DONE
    hit(1'b1, 1'b0, 6'd5, 6'd0);    // d_start lands with the re-arm in IDLE
    repeat (5) step();              // T+9
    total++; if (bus.valid !== 1'b1) begin bad++; $display("FAIL b2b_first_valid got=%b want=1", bus.valid); end
    total++; if (bus.interval !== 22'd10) begin bad++; $display("FAIL b2b_first_interval got=%0d want=10", bus.interval); end
    step();                         // T+10
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%b want=0", bus.busy); end
    do_arm();                       // T+11
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL b2b_rearm got=%b want=1", bus.busy); end
    hit(1'b1, 1'b1, 6'd30, 6'd10);  // -> T+12
    for (int k = 12; k < 20; k++) begin
      if (bus.valid) early = 1'b1;
      step();
    end                             // T+20
    total++; if (early !== 1'b0) begin bad++; $display("FAIL b2b_early got=%b want=0", early); end
    total++; if (bus.valid !== 1'b1) begin bad++; $display("FAIL b2b_second_valid got=%b want=1", bus.valid); end
    total++; if (bus.interval !== 22'd20) begin bad++; $display("FAIL b2b_second_interval got=%0d want=20", bus.interval); end
    step();
  endtask

  task automatic test_wrap_clamp();
    int n = 0;
    logic early = 1'b0;
    do_arm();
    while (tb_coarse !== 16'hFFF7 && n < 70000) begin
      step();
      n++;
    end
    total++; if (n >= 70000) begin bad++; $display("FAIL wrap_wait got=%0d want<70000", n); end
    hit(1'b1, 1'b0, 6'd63, 6'd0);   // d_start at coarse 0xFFFE, fine clamps to 40
    repeat (4) step();
    hit(1'b0, 1'b1, 6'd0, 6'd0);    // d_stop at coarse 0x0003
    for (int k = 6; k < 14; k++) begin
      if (bus.valid) early = 1'b1;
      step();
    end
    total++; if (early !== 1'b0) begin bad++; $display("FAIL wrap_early got=%b want=0", early); end
    total++; if (bus.valid !== 1'b1) begin bad++; $display("FAIL wrap_valid got=%b want=1", bus.valid); end
    total++; if (bus.interval !== 22'd240) begin bad++; $display("FAIL wrap_interval got=%0d want=240", bus.interval); end
    total++; if (bus.neg_err !== 1'b0) begin bad++; $display("FAIL wrap_neg_err got=%b want=0", bus.neg_err); end
    step();
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_timeout();
    test_same_cycle();
    test_ordering();
    test_reset_mid();
    test_back_to_back();
    test_wrap_clamp();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
